// File: rtl/posit_decode_scheduler.sv
// Shares one multi-cycle posit decoder between the two operands of a request, short-cutting
// zero/NaR, guarding each decode with a watchdog and presenting both decoded field sets.
module posit_decode_scheduler #(
  parameter int unsigned Timeout = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] dec_posit_o,
  output logic        dec_start_o,
  output logic        dec_received_o,
  input  logic        dec_done_i,
  input  logic        dec_sign_i,
  input  logic        dec_zero_i,
  input  logic        dec_nar_i,
  input  logic [5:0]  dec_k_i,
  input  logic [2:0]  dec_exp_i,
  input  logic [31:0] dec_mant_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        a_sign_o,
  output logic        a_zero_o,
  output logic        a_nar_o,
  output logic [5:0]  a_k_o,
  output logic [2:0]  a_exp_o,
  output logic [31:0] a_mant_o,
  output logic        b_sign_o,
  output logic        b_zero_o,
  output logic        b_nar_o,
  output logic [5:0]  b_k_o,
  output logic [2:0]  b_exp_o,
  output logic [31:0] b_mant_o,
  output logic [1:0]  out_timeout_o
);

  localparam int unsigned WdW = (Timeout > 2) ? $clog2(Timeout) : 1;

  typedef enum logic [2:0] {
    StIdle, StIssueA, StWaitA, StAckA, StIssueB, StWaitB, StAckB, StOut
  } state_e;

  state_e          state_q;
  logic [31:0]     opa_q, opb_q;
  logic [31:0]     dec_posit_q;
  logic            dec_start_q, dec_received_q;
  logic [WdW-1:0]  wdog_q;
  logic [1:0]      sign_q, zero_q, nar_q, timeout_q;
  logic [1:0][5:0] k_q;
  logic [1:0][2:0] exp_q;
  logic [1:0][31:0] mant_q;

  logic        is_b;
  logic [31:0] cur_op;
  logic        cur_special;

  always_comb begin
    is_b        = (state_q == StIssueB) || (state_q == StWaitB) || (state_q == StAckB);
    cur_op      = is_b ? opb_q : opa_q;
    cur_special = (cur_op == 32'h0000_0000) || (cur_op == 32'h8000_0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      opa_q          <= '0;
      opb_q          <= '0;
      dec_posit_q    <= '0;
      dec_start_q    <= 1'b0;
      dec_received_q <= 1'b0;
      wdog_q         <= '0;
      sign_q         <= '0;
      zero_q         <= '0;
      nar_q          <= '0;
      k_q            <= '0;
      exp_q          <= '0;
      mant_q         <= '0;
      timeout_q      <= '0;
    end else begin
      dec_start_q    <= 1'b0;
      dec_received_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            opa_q       <= op_a_i;
            opb_q       <= op_b_i;
            dec_posit_q <= op_a_i;
            sign_q      <= '0;
            zero_q      <= '0;
            nar_q       <= '0;
            k_q         <= '0;
            exp_q       <= '0;
            mant_q      <= '0;
            timeout_q   <= '0;
            state_q     <= StIssueA;
          end
        end
        StIssueA, StIssueB: begin
          if (cur_special) begin
            // Zero and NaR differ only in the sign bit, which doubles as the sign flag.
            sign_q[is_b] <= cur_op[31];
            zero_q[is_b] <= ~cur_op[31];
            nar_q[is_b]  <= cur_op[31];
            dec_posit_q  <= opb_q;
            state_q      <= is_b ? StOut : StIssueB;
          end else if (!dec_done_i) begin
            // A done still high here belongs to the previous decode; wait for it to drop.
            dec_start_q <= 1'b1;
            wdog_q      <= '0;
            state_q     <= is_b ? StWaitB : StWaitA;
          end
        end
        StWaitA, StWaitB: begin
          if (dec_done_i) begin
            sign_q[is_b]   <= dec_sign_i;
            zero_q[is_b]   <= dec_zero_i;
            nar_q[is_b]    <= dec_nar_i;
            k_q[is_b]      <= dec_k_i;
            exp_q[is_b]    <= dec_exp_i;
            mant_q[is_b]   <= dec_mant_i;
            dec_received_q <= 1'b1;
            state_q        <= is_b ? StAckB : StAckA;
          end else if (wdog_q == WdW'(Timeout - 1)) begin
            timeout_q[is_b] <= 1'b1;
            dec_received_q  <= 1'b1;
            state_q         <= is_b ? StAckB : StAckA;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StAckA, StAckB: begin
          dec_posit_q <= opb_q;
          state_q     <= is_b ? StOut : StIssueB;
        end
        StOut: begin
          if (out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign out_valid_o    = (state_q == StOut);
  assign dec_posit_o    = dec_posit_q;
  assign dec_start_o    = dec_start_q;
  assign dec_received_o = dec_received_q;
  assign out_timeout_o  = timeout_q;

  assign a_sign_o = sign_q[0];
  assign a_zero_o = zero_q[0];
  assign a_nar_o  = nar_q[0];
  assign a_k_o    = k_q[0];
  assign a_exp_o  = exp_q[0];
  assign a_mant_o = mant_q[0];
  assign b_sign_o = sign_q[1];
  assign b_zero_o = zero_q[1];
  assign b_nar_o  = nar_q[1];
  assign b_k_o    = k_q[1];
  assign b_exp_o  = exp_q[1];
  assign b_mant_o = mant_q[1];

endmodule

// File: doc/posit_decode_scheduler.md
# posit_decode_scheduler

Sequencer that shares one multi-cycle posit decoder between the two operands of a posit arithmetic request. It accepts an operand pair over a valid/ready handshake and resolves zero and NaR patterns directly, without using the decoder. Other operands go through the decoder one at a time using its start/done/received protocol. It then presents both sets of decoded fields to the downstream arithmetic stage over a second valid/ready handshake, and guards each decode with a watchdog.

## Interface
- TIMEOUT, 48: maximum cycles spent waiting for dec_done per operand before aborting.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  operand pair valid.
- req_ready  out  1  high only in IDLE.
- op_a, op_b  in  32 each  posit32 (es=3) operands, sampled on the accept edge.
- dec_posit  out  32  operand driven to the decoder; held stable from ISSUE through ACK.
- dec_start  out  1  one-cycle start pulse to the decoder.
- dec_received  out  1  one-cycle acknowledge to the decoder.
- dec_done  in  1  decoder completion.
- dec_sign, dec_zero, dec_nar  in  1 each  decoder result fields.
- dec_k  in  6 signed  regime value from the decoder.
- dec_exp  in  3  exponent field from the decoder.
- dec_mant  in  32  mantissa from the decoder, hidden bit at [31].
- out_valid  out  1  decoded pair valid.
- out_ready  in  1  downstream accepts the decoded pair.
- a_sign, a_zero, a_nar, b_sign, b_zero, b_nar  out  1 each  per-operand flags.
- a_k, b_k  out  6 signed each  per-operand regime value.
- a_exp, b_exp  out  3 each  per-operand exponent.
- a_mant, b_mant  out  32 each  per-operand mantissa.
- out_timeout  out  2  [0] operand A watchdog fired, [1] operand B watchdog fired.

## Operation
- States: IDLE, ISSUE_A, WAIT_A, ACK_A, ISSUE_B, WAIT_B, ACK_B, OUT.
- IDLE: req_ready=1. If req_valid, latch op_a/op_b, clear all result registers, go to ISSUE_A.
- ISSUE_x, special fast path:
  - operand == 32'h0000_0000: zero=1, sign=0, k=0, exp=0, mant=0.
  - operand == 32'h8000_0000: nar=1, sign=1, k=0, exp=0, mant=0.
  - Either case goes straight to ISSUE_B (from ISSUE_A) or OUT (from ISSUE_B). The decoder is not started.
- ISSUE_x, normal path:
  - Drive dec_posit = operand.
  - If dec_done==0: assert dec_start for this cycle only, clear the watchdog, go to WAIT_x.
  - If dec_done==1: stay in ISSUE_x and do not start. This prevents a stale done from a previous decode being taken as completion.
- WAIT_x, on dec_done==1: capture sign/zero/nar/k/exp/mant into the x registers, go to ACK_x.
- WAIT_x, watchdog: count cycles. When the count reaches TIMEOUT-1 with no done, set out_timeout[x], leave the x fields zero, go to ACK_x.
- ACK_x: dec_received=1 for exactly one cycle (also on timeout, to release a hung decoder). Then go to ISSUE_B (from ACK_A) or OUT (from ACK_B).
- OUT: out_valid=1 and all a_*/b_*/out_timeout held stable until out_ready. On the cycle out_valid && out_ready, go to IDLE.
- Captured fields are copied verbatim; no width conversion. dec_k stays 6-bit two's complement.
- dec_start, dec_received and dec_posit are registered; no combinational path from dec_done.

## Timing
- Reset (async, rst=0): state=IDLE, and every output is 0 (req_ready becomes 1 once IDLE is decoded). The watchdog and latched operands also clear.
- Reset mid-operation aborts immediately. Any in-flight decode is discarded; the decoder shares rst.
- Both operands special: accept at edge T; ISSUE_A during T..T+1; ISSUE_B during T+1..T+2; out_valid high from T+2.
- Normal operand:
  - dec_start is high for the one cycle after entry to ISSUE_x (when dec_done is already low).
  - Capture happens on the first edge with dec_done=1 seen in WAIT_x.
  - dec_received is high during the following cycle.
  - Controller overhead is 3 cycles per operand beyond decoder latency.
- Back-to-back requests: the OUT handshake edge returns to IDLE. req_ready is high the next cycle, so there is a one-cycle bubble minimum.
- req_valid outside IDLE is ignored; op_a/op_b may change freely then.
- out_ready held high in advance: OUT lasts exactly one cycle.

## Test plan
- Both special: op_a=0x00000000, op_b=0x80000000 → out_valid 2 cycles after accept; a_zero=1, b_nar=1, b_sign=1, all k/exp/mant=0, decoder never started.
- Normal pair: op_a=0x40000000, op_b=0xC0000000 → a: sign0 k=0 exp=0 mant=0x80000000; b: sign1, same k/exp/mant. Exactly two dec_start and two dec_received pulses.
- Exponent field: op_a=0x48000000, op_b=0x00000000 → a_k=0, a_exp=2, a_mant=0x80000000; b_zero=1; one decode only.
- Stale done: hold dec_done=1 on entry to ISSUE_A (model) → no dec_start until dec_done falls, then a normal decode.
- Watchdog: decoder model never asserts done for op_a=0x40000000 → out_timeout=2'b01 at cycle TIMEOUT; dec_received pulses once; B still decoded.
- Backpressure and reset: hold out_ready=0 for 10 cycles (outputs stable), then pulse rst low during WAIT_B → all outputs 0, state IDLE, req_ready=1 after release.
